// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - operand capture and skewed A/B stream feeder for a DIMxDIM systolic array
module systolic_feeder #(
    parameter int WIDTH       = 32,
    parameter int DIM         = 4,
    parameter int DRAIN_EXTRA = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_mat [DIM][DIM],
    input  logic [WIDTH-1:0] b_mat [DIM][DIM],
    output logic             acc_clr,
    output logic [WIDTH-1:0] a_out [DIM],
    output logic [WIDTH-1:0] b_out [DIM],
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(2 * DIM + DRAIN_EXTRA);
    localparam logic [CW-1:0] FEED_LAST  = CW'(2 * DIM - 2);
    // Drain spans DIM+DRAIN_EXTRA cycles so done lands in cycle 3*DIM+DRAIN_EXTRA+1 after the handshake.
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DIM - 1 + DRAIN_EXTRA);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg [DIM][DIM];
    logic [WIDTH-1:0] b_reg [DIM][DIM];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            acc_clr  <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg    <= a_mat;
                        b_reg    <= b_mat;
                        state    <= CLEAR;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        acc_clr  <= 1'b1;
                    end
                end
                CLEAR: begin
                    state   <= FEED;
                    acc_clr <= 1'b0;
                    cnt     <= '0;
                end
                FEED: begin
                    if (cnt == FEED_LAST) begin
                        state <= DRAIN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    acc_clr  <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    // Row i carries A[i][k] and column j carries B[k][j] at feed step t = i+k (resp. j+k).
    always_comb begin
        for (int i = 0; i < DIM; i++) begin
            a_out[i] = '0;
            b_out[i] = '0;
        end
        if (state == FEED) begin
            for (int i = 0; i < DIM; i++) begin
                for (int k = 0; k < DIM; k++) begin
                    if (int'(cnt) == i + k) begin
                        a_out[i] = a_reg[i][k];
                        b_out[i] = b_reg[k][i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - schedule-model bench for systolic_feeder with a behavioural array attached
module tb_systolic_feeder;

    localparam int W     = 32;
    localparam int D     = 4;
    localparam int DE    = 1;
    localparam int TOTAL = 3 * D + DE + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready, acc_clr, busy, done;
    logic [W-1:0] a_mat [D][D];
    logic [W-1:0] b_mat [D][D];
    logic [W-1:0] a_out [D];
    logic [W-1:0] b_out [D];

    systolic_feeder #(.WIDTH(W), .DIM(D), .DRAIN_EXTRA(DE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_mat(a_mat), .b_mat(b_mat), .acc_clr(acc_clr),
        .a_out(a_out), .b_out(b_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Job schedule model: age is the cycle number since the capture edge (0 = idle).
    int           edges = 0;
    int           age = 0;
    int           cap_edge = -1;
    logic [W-1:0] cap_a [D][D];
    logic [W-1:0] cap_b [D][D];
    logic [W-1:0] prod  [D][D];

    always @(posedge clk) begin
        edges++;
        if (rst) age = 0;
        else if (age == 0) begin
            if (in_valid) begin
                age = 1;
                cap_edge = edges;
                cap_a = a_mat;
                cap_b = b_mat;
                for (int i = 0; i < D; i++)
                    for (int j = 0; j < D; j++) begin
                        logic [W-1:0] s;
                        s = '0;
                        for (int k = 0; k < D; k++) s += cap_a[i][k] * cap_b[k][j];
                        prod[i][j] = s;
                    end
            end
        end else age = (age == TOTAL) ? 0 : age + 1;
    end

    function automatic logic [W-1:0] exp_a(input int i);
        int t = age - 2;
        if (age >= 2 && age <= 2 * D && t - i >= 0 && t - i < D) return cap_a[i][t-i];
        return '0;
    endfunction

    function automatic logic [W-1:0] exp_b(input int j);
        int t = age - 2;
        if (age >= 2 && age <= 2 * D && t - j >= 0 && t - j < D) return cap_b[t-j][j];
        return '0;
    endfunction

    // Output-stationary array fed by the DUT streams; compared when done fires.
    logic [W-1:0] ar [D][D];
    logic [W-1:0] br [D][D];
    logic [W-1:0] c  [D][D];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, age == 0);
            chk("busy", busy, age != 0);
            chk("acc_clr", acc_clr, age == 1);
            chk("done", done, age == TOTAL);
            for (int i = 0; i < D; i++) begin
                chk("a_out", a_out[i], exp_a(i));
                chk("b_out", b_out[i], exp_b(i));
            end
            if (age == TOTAL)
                for (int i = 0; i < D; i++)
                    for (int j = 0; j < D; j++) chk("c_out", c[i][j], prod[i][j]);
        end
        if (acc_clr === 1'b1) begin
            for (int i = 0; i < D; i++)
                for (int j = 0; j < D; j++) begin
                    ar[i][j] = '0; br[i][j] = '0; c[i][j] = '0;
                end
        end else begin
            for (int i = D - 1; i >= 0; i--)
                for (int j = D - 1; j >= 0; j--) begin
                    logic [W-1:0] ai, bi;
                    ai = (j == 0) ? a_out[i] : ar[i][j-1];
                    bi = (i == 0) ? b_out[j] : br[i-1][j];
                    ar[i][j] = ai;
                    br[i][j] = bi;
                    c[i][j] = c[i][j] + ai * bi;
                end
        end
    end

    task automatic fill_rand();
        for (int i = 0; i < D; i++)
            for (int k = 0; k < D; k++) begin
                a_mat[i][k] = $urandom;
                b_mat[i][k] = $urandom;
            end
    endtask

    task automatic start_job(output int e0);
        int g = 0;
        while (in_ready !== 1'b1 && g < 100) begin @(negedge clk); g++; end
        if (g >= 100) timeout("start_job");
        in_valid = 1'b1;
        @(negedge clk);
        e0 = cap_edge;
    endtask

    task automatic at_cycle(input int e0, input int n);
        int g = 0;
        while (edges < e0 + n - 1 && g < 200) begin @(negedge clk); g++; end
        if (edges != e0 + n - 1) timeout("at_cycle");
    endtask

    task automatic wait_idle();
        int g = 0;
        while (in_ready !== 1'b1 && g < 100) begin @(negedge clk); g++; end
        if (g >= 100) timeout("wait_idle");
    endtask

    initial begin
        int e0;
        int nd;
        bit hold;
        fill_rand();
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_acc_clr", acc_clr, 0);
        for (int i = 0; i < D; i++) begin
            chk("rst_a_out", a_out[i], 0);
            chk("rst_b_out", b_out[i], 0);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("no_capture_busy", busy, 0);

        // Skew pattern, with inputs disturbed while the job runs.
        for (int i = 0; i < D; i++)
            for (int k = 0; k < D; k++) begin
                a_mat[i][k] = 16 * i + k + 1;
                b_mat[i][k] = 16 * i + k + 'h100;
            end
        start_job(e0);
        in_valid = 1'b0;
        at_cycle(e0, 2);
        chk("skew_t0_a0", a_out[0], 1);
        chk("skew_t0_b0", b_out[0], 'h100);
        chk("skew_t0_a3", a_out[3], 0);
        at_cycle(e0, 3);
        fill_rand();
        in_valid = 1'b1;
        at_cycle(e0, 4);
        in_valid = 1'b0;
        fill_rand();
        at_cycle(e0, 5);
        chk("skew_t3_a0", a_out[0], 4);
        chk("skew_t3_a1", a_out[1], 'h13);
        chk("skew_t3_a2", a_out[2], 'h22);
        chk("skew_t3_a3", a_out[3], 'h31);
        chk("skew_t3_b0", b_out[0], 'h130);
        chk("skew_t3_b1", b_out[1], 'h121);
        chk("skew_t3_b2", b_out[2], 'h112);
        chk("skew_t3_b3", b_out[3], 'h103);
        at_cycle(e0, 8);
        chk("skew_t6_a2", a_out[2], 0);
        chk("skew_t6_a3", a_out[3], 'h34);
        chk("skew_t6_b3", b_out[3], 'h133);
        at_cycle(e0, 9);
        for (int i = 0; i < D; i++) begin
            chk("skew_c9_a", a_out[i], 0);
            chk("skew_c9_b", b_out[i], 0);
        end
        at_cycle(e0, 14);
        chk("skew_done14", done, 1);
        wait_idle();

        // End-to-end: identity, then doubled identity to show the clear.
        for (int i = 0; i < D; i++)
            for (int k = 0; k < D; k++) begin
                a_mat[i][k] = (i == k) ? 1 : 0;
                b_mat[i][k] = 4 * i + k;
            end
        start_job(e0);
        in_valid = 1'b0;
        at_cycle(e0, 13);
        chk("e2e_done13", done, 0);
        at_cycle(e0, 14);
        chk("e2e_done14", done, 1);
        for (int i = 0; i < D; i++)
            for (int j = 0; j < D; j++) chk("e2e_c_eq_b", c[i][j], 4 * i + j);
        wait_idle();
        for (int i = 0; i < D; i++) a_mat[i][i] = 2;
        start_job(e0);
        in_valid = 1'b0;
        at_cycle(e0, 14);
        for (int i = 0; i < D; i++)
            for (int j = 0; j < D; j++) chk("e2e_c_eq_2b", c[i][j], 8 * i + 2 * j);
        wait_idle();

        // Back-to-back with in_valid held high.
        fill_rand();
        start_job(e0);
        at_cycle(e0, 14);
        chk("b2b_busy14", busy, 1);
        fill_rand();
        at_cycle(e0, 15);
        chk("b2b_busy15", busy, 0);
        chk("b2b_ready15", in_ready, 1);
        at_cycle(e0, 16);
        chk("b2b_busy16", busy, 1);
        chk("b2b_clr16", acc_clr, 1);
        in_valid = 1'b0;
        wait_idle();

        // Reset in the middle of FEED.
        fill_rand();
        start_job(e0);
        in_valid = 1'b0;
        at_cycle(e0, 5);
        rst = 1'b1;
        at_cycle(e0, 6);
        rst = 1'b0;
        chk("midrst_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        for (int i = 0; i < D; i++) chk("midrst_a_out", a_out[i], 0);
        nd = 0;
        repeat (12) begin @(negedge clk); if (done === 1'b1) nd++; end
        chk("midrst_no_done", nd, 0);
        fill_rand();
        start_job(e0);
        in_valid = 1'b0;
        at_cycle(e0, 14);
        chk("midrst_fresh_done", done, 1);
        wait_idle();

        // Randomized traffic with occasional resets.
        hold = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (cyc % 200 == 0) hold = $urandom_range(0, 1);
            rst = ($urandom_range(0, 199) == 0);
            in_valid = hold ? 1'b1 : ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) fill_rand();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
